// File: rtl/fsmc_slave_arbiter.sv
// fsmc_slave_arbiter: schedules decoded FSMC bus transactions onto N_SLAVE register slots
//
// One transaction is active at a time and one more can wait in a depth-1 pending
// buffer. The active transaction drives a one-hot req/ack handshake to its slot,
// then reports completion with a one-cycle done pulse, qualified by an error flag.
//
// Optional feature macro: FSMC_ARB_TIMEOUT_EN
//   defined   - a REQ that stays unacknowledged for TIMEOUT cycles completes with error
//   undefined - REQ waits for slv_ack_i indefinitely
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   bus_req_i    one-cycle transaction pulse from the bus interface
//   bus_wr_i     1 = write, 0 = read (valid with bus_req_i)
//   bus_sel_i    binary slot index (valid with bus_req_i)
//   bus_wdata_i  write data (valid with bus_req_i)
//   bus_rdata_o  read data, valid with bus_done_o and held afterwards
//   bus_done_o   one-cycle completion pulse
//   bus_err_o    qualifies bus_done_o: invalid slot or timeout
//   bus_busy_o   active transaction or pending buffer occupied
//   bus_ovf_o    sticky: a bus_req_i was dropped because the buffer was full
//   slv_req_o    one-hot slot request
//   slv_wr_o     direction of the current request
//   slv_wdata_o  write data of the current request
//   slv_ack_i    per-slot acknowledge
//   slv_rdata_i  per-slot read data, slot i at [i*DW +: DW]
module fsmc_slave_arbiter #(
    parameter int             N_SLAVE   = 4,
    parameter int             DW        = 16,
    parameter int             TIMEOUT   = 8,
    parameter logic [DW-1:0]  IDLE_DATA = DW'(16'hDEAD)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 bus_req_i,
    input  logic                 bus_wr_i,
    input  logic [3:0]           bus_sel_i,
    input  logic [DW-1:0]        bus_wdata_i,
    output logic [DW-1:0]        bus_rdata_o,
    output logic                 bus_done_o,
    output logic                 bus_err_o,
    output logic                 bus_busy_o,
    output logic                 bus_ovf_o,
    output logic [N_SLAVE-1:0]   slv_req_o,
    output logic                 slv_wr_o,
    output logic [DW-1:0]        slv_wdata_o,
    input  logic [N_SLAVE-1:0]   slv_ack_i,
    input  logic [N_SLAVE*DW-1:0] slv_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_q, state_d;
    logic          cur_wr_q, cur_wr_d;
    logic [3:0]    cur_sel_q, cur_sel_d;
    logic [DW-1:0] cur_wdata_q, cur_wdata_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_wr_q, pend_wr_d;
    logic [3:0]    pend_sel_q, pend_sel_d;
    logic [DW-1:0] pend_wdata_q, pend_wdata_d;
    logic          ovf_q, ovf_d;

    logic          ack_sel;
    logic [DW-1:0] sel_rdata;
    logic          launch;
    logic          l_wr;
    logic [3:0]    l_sel;
    logic [DW-1:0] l_wdata;

`ifdef FSMC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Route the addressed slot's ack/rdata and fan the one-hot request out.
    always_comb begin
        ack_sel   = 1'b0;
        sel_rdata = '0;
        slv_req_o = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (cur_sel_q == 4'(i)) begin
                ack_sel      = slv_ack_i[i];
                sel_rdata    = slv_rdata_i[i*DW +: DW];
                slv_req_o[i] = (state_q == REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_wr_d     = cur_wr_q;
        cur_sel_d    = cur_sel_q;
        cur_wdata_d  = cur_wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        pend_valid_d = pend_valid_q;
        pend_wr_d    = pend_wr_q;
        pend_sel_d   = pend_sel_q;
        pend_wdata_d = pend_wdata_q;
        ovf_d        = ovf_q;
`ifdef FSMC_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        launch       = 1'b0;
        l_wr         = bus_wr_i;
        l_sel        = bus_sel_i;
        l_wdata      = bus_wdata_i;
        // A request arriving while busy is buffered in REQ; in DONE with an empty
        // buffer it is launched straight away (see DONE below), otherwise dropped.
        if (bus_req_i && state_q != IDLE) begin
            if (pend_valid_q) begin
                ovf_d = 1'b1;
            end else if (state_q == REQ) begin
                pend_valid_d = 1'b1;
                pend_wr_d    = bus_wr_i;
                pend_sel_d   = bus_sel_i;
                pend_wdata_d = bus_wdata_i;
            end
        end
        unique case (state_q)
            IDLE: launch = bus_req_i;
            REQ: begin
                if (ack_sel) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    rdata_d = cur_wr_q ? rdata_q : sel_rdata;
                end
`ifdef FSMC_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = IDLE_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (pend_valid_q) begin
                    launch       = 1'b1;
                    l_wr         = pend_wr_q;
                    l_sel        = pend_sel_q;
                    l_wdata      = pend_wdata_q;
                    pend_valid_d = 1'b0;
                end else begin
                    launch  = bus_req_i;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Launching a transaction: invalid slots complete immediately with error.
        if (launch) begin
            cur_wr_d    = l_wr;
            cur_sel_d   = l_sel;
            cur_wdata_d = l_wdata;
            if ({1'b0, l_sel} < 5'(N_SLAVE)) begin
                state_d = REQ;
                err_d   = 1'b0;
`ifdef FSMC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end else begin
                state_d = DONE;
                err_d   = 1'b1;
                rdata_d = IDLE_DATA;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cur_wr_q     <= 1'b0;
            cur_sel_q    <= '0;
            cur_wdata_q  <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_sel_q   <= '0;
            pend_wdata_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_wr_q     <= cur_wr_d;
            cur_sel_q    <= cur_sel_d;
            cur_wdata_q  <= cur_wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            pend_valid_q <= pend_valid_d;
            pend_wr_q    <= pend_wr_d;
            pend_sel_q   <= pend_sel_d;
            pend_wdata_q <= pend_wdata_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef FSMC_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`endif

    assign bus_rdata_o = rdata_q;
    assign bus_done_o  = (state_q == DONE);
    assign bus_err_o   = (state_q == DONE) && err_q;
    assign bus_busy_o  = (state_q != IDLE) || pend_valid_q;
    assign bus_ovf_o   = ovf_q;
    assign slv_wr_o    = cur_wr_q;
    assign slv_wdata_o = cur_wdata_q;
endmodule

// File: tb/tb_fsmc_slave_arbiter.sv
// tb_fsmc_slave_arbiter: directed self-checking bench for fsmc_slave_arbiter
module tb_fsmc_slave_arbiter;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        bus_req_i, bus_wr_i;
    logic [3:0]  bus_sel_i;
    logic [15:0] bus_wdata_i, bus_rdata_o, slv_wdata_o;
    logic        bus_done_o, bus_err_o, bus_busy_o, bus_ovf_o, slv_wr_o;
    logic [3:0]  slv_req_o, slv_ack_i;
    logic [63:0] slv_rdata_i;
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int snap, n;

    fsmc_slave_arbiter dut (
        .clk_i(clk), .reset_i(reset_i),
        .bus_req_i(bus_req_i), .bus_wr_i(bus_wr_i), .bus_sel_i(bus_sel_i),
        .bus_wdata_i(bus_wdata_i), .bus_rdata_o(bus_rdata_o), .bus_done_o(bus_done_o),
        .bus_err_o(bus_err_o), .bus_busy_o(bus_busy_o), .bus_ovf_o(bus_ovf_o),
        .slv_req_o(slv_req_o), .slv_wr_o(slv_wr_o), .slv_wdata_o(slv_wdata_o),
        .slv_ack_i(slv_ack_i), .slv_rdata_i(slv_rdata_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus_done_o === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [3:0] sel, input logic [15:0] wd);
        bus_req_i   = 1'b1;
        bus_wr_i    = wr;
        bus_sel_i   = sel;
        bus_wdata_i = wd;
    endtask

    initial begin
        reset_i = 1'b1;
        bus_req_i = 0; bus_wr_i = 0; bus_sel_i = 0; bus_wdata_i = 0;
        slv_ack_i = 0;
        slv_rdata_i = {16'h3333, 16'h2321, 16'h1A1A, 16'h0A0A};
        tick(); tick();
        chk("reset_outputs", {bus_rdata_o, bus_done_o, bus_err_o, bus_busy_o, bus_ovf_o, slv_req_o, slv_wr_o},
            32'h0);
        reset_i = 1'b0;
        tick();

        // write to slot 1, ack in first REQ cycle
        issue(1'b1, 4'd1, 16'h0F0F);
        slv_ack_i = 4'b0010;
        tick();
        bus_req_i = 1'b0;
        chk("wr_req", slv_req_o, 4'b0010);
        chk("wr_wdata", {slv_wr_o, slv_wdata_o}, {1'b1, 16'h0F0F});
        chk("wr_no_done_yet", bus_done_o, 1'b0);
        tick();
        slv_ack_i = 0;
        chk("wr_done", {bus_done_o, bus_err_o, slv_req_o}, {1'b1, 1'b0, 4'b0000});
        chk("wr_rdata_untouched", bus_rdata_o, 16'h0000);
        tick();
        chk("wr_idle", {bus_done_o, bus_busy_o}, 2'b00);

        // read from slot 2, ack after 3 REQ cycles
        issue(1'b0, 4'd2, 16'h0000);
        tick();
        bus_req_i = 1'b0;
        chk("rd_req1", slv_req_o, 4'b0100);
        tick(); tick();
        chk("rd_req3", {slv_req_o, bus_done_o}, {4'b0100, 1'b0});
        slv_ack_i = 4'b0100;
        tick();
        slv_ack_i = 0;
        chk("rd_done", {bus_done_o, bus_err_o, bus_rdata_o}, {1'b1, 1'b0, 16'h2321});
        tick();
        chk("rd_after", {bus_done_o, bus_busy_o, bus_rdata_o}, {1'b0, 1'b0, 16'h2321});

        // invalid slot
        issue(1'b0, 4'd5, 16'h0000);
        tick();
        bus_req_i = 1'b0;
        chk("inv_done", {bus_done_o, bus_err_o, slv_req_o, bus_rdata_o}, {1'b1, 1'b1, 4'b0000, 16'hDEAD});
        tick();
        chk("inv_after", {bus_done_o, bus_err_o, bus_busy_o}, 3'b000);

        // unacknowledged read to slot 0
        issue(1'b0, 4'd0, 16'h0000);
        tick();
        bus_req_i = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_done_o) break;
            if (slv_req_o == 4'b0001) n++;
            tick();
        end
`ifdef FSMC_ARB_TIMEOUT_EN
        chk("to_req_cycles", n, 8);
        chk("to_done", {bus_done_o, bus_err_o, slv_req_o, bus_rdata_o}, {1'b1, 1'b1, 4'b0000, 16'hDEAD});
        tick();
        // ack arriving in the final REQ cycle beats the timeout
        issue(1'b0, 4'd0, 16'h0000);
        tick();
        bus_req_i = 1'b0;
        repeat (7) tick();
        chk("to_last_req", {slv_req_o, bus_done_o}, {4'b0001, 1'b0});
        slv_ack_i = 4'b0001;
        tick();
        slv_ack_i = 0;
        chk("to_ack_wins", {bus_done_o, bus_err_o, bus_rdata_o}, {1'b1, 1'b0, 16'h0A0A});
`else
        chk("noto_req_held", {slv_req_o, bus_done_o, 32'(n)}, {4'b0001, 1'b0, 32'd30});
        slv_ack_i = 4'b0001;
        tick();
        slv_ack_i = 0;
        chk("noto_ack_done", {bus_done_o, bus_err_o, bus_rdata_o}, {1'b1, 1'b0, 16'h0A0A});
`endif
        tick();
        chk("to_idle", {bus_busy_o, bus_ovf_o}, 2'b00);

        // buffering and overflow: slots 0, 1, 3 on consecutive cycles
        snap = done_cnt;
        issue(1'b0, 4'd0, 16'h0000);
        tick();
        issue(1'b0, 4'd1, 16'h0000);
        tick();
        issue(1'b0, 4'd3, 16'h0000);
        tick();
        bus_req_i = 1'b0;
        chk("buf_ovf", {bus_ovf_o, bus_busy_o, slv_req_o}, {1'b1, 1'b1, 4'b0001});
        slv_ack_i = 4'b0001;
        tick();
        slv_ack_i = 4'b0010;
        chk("buf_done0", {bus_done_o, bus_err_o, bus_rdata_o, slv_req_o}, {1'b1, 1'b0, 16'h0A0A, 4'b0000});
        tick();
        chk("buf_req1", {slv_req_o, bus_done_o}, {4'b0010, 1'b0});
        tick();
        slv_ack_i = 0;
        chk("buf_done1", {bus_done_o, bus_err_o, bus_rdata_o}, {1'b1, 1'b0, 16'h1A1A});
        tick();
        chk("buf_idle", {bus_done_o, bus_busy_o, slv_req_o, bus_ovf_o}, {1'b0, 1'b0, 4'b0000, 1'b1});
        tick(); tick();
        chk("buf_done_pulses", done_cnt - snap, 2);
        chk("buf_ovf_sticky", bus_ovf_o, 1'b1);

        // reset while slot 1 is requested
        issue(1'b1, 4'd1, 16'h5555);
        tick();
        bus_req_i = 1'b0;
        chk("rst_req", slv_req_o, 4'b0010);
        snap = done_cnt;
        #1 reset_i = 1'b1;
        #1;
        chk("rst_async", {bus_rdata_o, bus_done_o, bus_err_o, bus_busy_o, bus_ovf_o, slv_req_o, slv_wr_o},
            32'h0);
        tick();
        reset_i = 1'b0;
        tick(); tick();
        chk("rst_after", {bus_done_o, bus_busy_o, slv_req_o, 32'(done_cnt - snap)}, 32'h0);

        // normal operation resumes
        issue(1'b1, 4'd3, 16'hBEEF);
        slv_ack_i = 4'b1000;
        tick();
        bus_req_i = 1'b0;
        chk("resume_req", {slv_req_o, slv_wdata_o}, {4'b1000, 16'hBEEF});
        tick();
        slv_ack_i = 0;
        chk("resume_done", {bus_done_o, bus_err_o}, 2'b10);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fsmc_slave_arbiter.md
# fsmc_slave_arbiter

Transaction scheduler between the FSMC bus interface and up to `N_SLAVE` register-mapped peripheral slots. It accepts one decoded bus transaction at a time, holds one extra transaction in a pending buffer, and drives a request/acknowledge handshake to the addressed slot. It returns read data, a completion strobe and an error flag to the bus interface. A timeout optionally protects the FSMC read window against a slot that never acknowledges.

## Interface
Parameters:
- `N_SLAVE`, 4, number of slave slots (1..16)
- `DW`, 16, data width
- `TIMEOUT`, 8, maximum cycles `slv_req` stays high without `slv_ack` (≥2)
- `IDLE_DATA`, 16'hDEAD, read data returned on error

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `bus_req`  in  1  one-cycle pulse: transaction decoded by bus interface
- `bus_wr`  in  1  1 = write, 0 = read; valid with `bus_req`
- `bus_sel`  in  4  binary slot index; valid with `bus_req`
- `bus_wdata`  in  DW  write data; valid with `bus_req`
- `bus_rdata`  out  DW  read data, valid while `bus_done`=1, held afterwards
- `bus_done`  out  1  one-cycle completion pulse
- `bus_err`  out  1  qualifies `bus_done`: invalid slot or timeout
- `bus_busy`  out  1  FSM not IDLE or pending buffer occupied
- `bus_ovf`  out  1  sticky: a `bus_req` was dropped
- `slv_req`  out  N_SLAVE  one-hot request, at most one bit high
- `slv_wr`  out  1  direction of current request
- `slv_wdata`  out  DW  write data of current request
- `slv_ack`  in  N_SLAVE  per-slot acknowledge, 1 cycle or level
- `slv_rdata`  in  N_SLAVE*DW  per-slot read data; slot i at `[i*DW +: DW]`, valid with `slv_ack[i]`

## Operation
- Reset values: all outputs 0, `bus_rdata`=0, FSM IDLE, pending empty, timeout counter 0.
- States: IDLE, REQ, DONE.
- IDLE and `bus_req`:
  - Register `bus_wr`, `bus_sel` and `bus_wdata` into the current transaction.
  - Valid `sel` (< N_SLAVE): go to REQ.
  - Invalid `sel`: go to DONE with err=1 and rdata=IDLE_DATA. No slot is strobed.
- REQ:
  - `slv_req[sel]`=1; `slv_wr` and `slv_wdata` stable.
  - On `slv_ack[sel]`=1: capture `slv_rdata` slot `sel` (reads only; writes leave `bus_rdata` unchanged) and go to DONE with err=0.
  - Acks on other slots are ignored.
- DONE:
  - `bus_done`=1 for 1 cycle, `bus_err` per the cause; `slv_req`=0.
  - Next state: if pending is valid, load it as the current transaction (slot check as in IDLE) and go to REQ or DONE. Otherwise go to IDLE.
- Pending buffer (depth 1):
  - `bus_req` while not in IDLE is stored if the buffer is empty.
  - If the buffer is full, the request is dropped and `bus_ovf` is set to 1 until reset.
  - `bus_req` in DONE while pending is empty is stored and launched next cycle.
- `bus_busy` = (state≠IDLE) | pending_valid.
- Reset mid-transaction: the request drops immediately (async), pending is discarded, and no `bus_done` is issued.

## Timing
- `bus_req` sampled at edge 0 → `slv_req` high after edge 1.
- `slv_ack` sampled at edge k → `slv_req` low and `bus_done` high after edge k+1.
- Minimum latency, with ack in the first REQ cycle: `bus_req` → `bus_done` = 2 cycles.
- Invalid slot: `bus_done`/`bus_err` after edge 1 (latency 1).
- Back-to-back transactions: the pending transaction's `slv_req` rises 1 cycle after the previous `bus_done`.
- Timeout counter: clears on entry to REQ and increments on each REQ cycle without ack. When it reaches TIMEOUT, the FSM goes to DONE with err=1 and rdata=IDLE_DATA.
- An ack arriving in the same cycle the counter reaches TIMEOUT wins: err=0.

## Configuration
- `FSMC_ARB_TIMEOUT_EN` defined: timeout counter and timeout error path compiled in, as specified above.
- Not defined: no counter. REQ waits for `slv_ack` indefinitely, and `bus_err` is raised only for an invalid slot.

## Test plan
- Write, normal ack: `bus_req`, wr=1, sel=1, wdata=16'h0F0F; ack on slot 1 in its first REQ cycle → `slv_req`=4'b0010 for 1 cycle with `slv_wdata`=16'h0F0F; `bus_done` 2 cycles after `bus_req`, err=0.
- Read: sel=2; slot 2 drives 16'h2321 with ack after 3 REQ cycles → `bus_rdata`=16'h2321 with `bus_done`, err=0; `bus_busy` low the cycle after.
- Invalid slot: sel=5 with N_SLAVE=4 → no `slv_req` bit; `bus_done`=1, `bus_err`=1, `bus_rdata`=16'hDEAD 1 cycle later.
- Timeout (macro defined, TIMEOUT=8): read to slot 0, no ack → `slv_req[0]` high exactly 8 cycles, then `bus_done`+`bus_err`, rdata=16'hDEAD. Macro undefined: `slv_req[0]` remains high.
- Buffering and overflow: three `bus_req` on consecutive cycles (slots 0, 1, 3) with slot 0 slow → slots 0 and 1 served in order; third request dropped, `bus_ovf`=1 and sticky; exactly two `bus_done` pulses.
- Reset mid-REQ: `reset` asserted while `slv_req[1]`=1 → all outputs 0 immediately; after release, FSM is IDLE with no spurious `bus_done`.
